// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity modes and oversample reload value.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    // Receiver state encodings, kept alongside the transmitter's.
    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam logic [3:0] OVS_RELOAD = 4'd15;

endpackage

// File: rtl/uart_tx_ctl.sv
// UART transmitter: one-entry holding buffer feeding a 16x-oversampled serialiser.
// Frame: start, DATA_BITS data LSB first, optional parity, 1 or 2 stop bits.
module uart_tx_ctl
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_baud_x16_en,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    output logic                 o_tx,
    output logic                 o_tx_busy,
    output logic                 o_tx_done
);

    localparam int BIT_CNT_W = ($clog2(DATA_BITS) > 3) ? $clog2(DATA_BITS) : 3;

    tx_state_e              state_q, state_d;
    logic [DATA_BITS-1:0]   buf_q, buf_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   buf_full_q, buf_full_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;
    logic                   done_q, done_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic [3:0]             ovs_q, ovs_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   accept;
    logic                   drain;
    logic                   ovs_zero;

    assign accept   = i_tx_valid && !buf_full_q;
    assign ovs_zero = (ovs_q == 4'd0);

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        shift_d    = shift_q;
        buf_full_d = buf_full_q;
        par_d      = par_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        stop_cnt_d = stop_cnt_q;
        ovs_d      = ovs_q;
        bit_cnt_d  = bit_cnt_q;
        drain      = 1'b0;

        if (accept) begin
            buf_d      = i_tx_data;
            buf_full_d = 1'b1;
        end

        if (i_baud_x16_en) begin
            unique case (state_q)
                TX_IDLE: begin
                    if (buf_full_q) begin
                        state_d = TX_START;
                        tx_d    = 1'b0;
                        ovs_d   = OVS_RELOAD;
                        drain   = 1'b1;
                    end
                end
                TX_START: begin
                    if (ovs_zero) begin
                        state_d   = TX_DATA;
                        tx_d      = shift_q[0];
                        bit_cnt_d = '0;
                        ovs_d     = OVS_RELOAD;
                    end else begin
                        ovs_d = ovs_q - 4'd1;
                    end
                end
                TX_DATA: begin
                    if (ovs_zero) begin
                        ovs_d = OVS_RELOAD;
                        if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
                            if (PARITY != PAR_NONE) begin
                                state_d = TX_PARITY;
                                tx_d    = par_q;
                            end else begin
                                state_d    = TX_STOP;
                                tx_d       = 1'b1;
                                stop_cnt_d = 1'b0;
                            end
                        end else begin
                            shift_d   = shift_q >> 1;
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            tx_d      = shift_q[1];
                        end
                    end else begin
                        ovs_d = ovs_q - 4'd1;
                    end
                end
                TX_PARITY: begin
                    if (ovs_zero) begin
                        state_d    = TX_STOP;
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                        ovs_d      = OVS_RELOAD;
                    end else begin
                        ovs_d = ovs_q - 4'd1;
                    end
                end
                TX_STOP: begin
                    if (ovs_zero) begin
                        ovs_d = OVS_RELOAD;
                        if (STOP_BITS == 2 && !stop_cnt_q) begin
                            stop_cnt_d = 1'b1;
                        end else begin
                            done_d = 1'b1;
                            // A waiting word starts immediately: no idle gap between frames.
                            if (buf_full_q) begin
                                state_d = TX_START;
                                tx_d    = 1'b0;
                                drain   = 1'b1;
                            end else begin
                                state_d = TX_IDLE;
                            end
                        end
                    end else begin
                        ovs_d = ovs_q - 4'd1;
                    end
                end
                default: begin
                    state_d = TX_IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end

        // Drain and accept are mutually exclusive: accept needs the buffer empty.
        if (drain) begin
            shift_d    = buf_q;
            par_d      = (PARITY == PAR_ODD) ? ~(^buf_q) : (^buf_q);
            buf_full_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= TX_IDLE;
            buf_q      <= '0;
            shift_q    <= '0;
            buf_full_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            stop_cnt_q <= 1'b0;
            ovs_q      <= '0;
            bit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            shift_q    <= shift_d;
            buf_full_q <= buf_full_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            stop_cnt_q <= stop_cnt_d;
            ovs_q      <= ovs_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign o_tx_ready = !buf_full_q;
    assign o_tx       = tx_q;
    assign o_tx_busy  = (state_q != TX_IDLE);
    assign o_tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_ctl.sv
// Self-checking bench for uart_tx_ctl: four instances (8N1, 8E1, 8O1, 8N2) driven by
// a vector table plus hand-written back-to-back and mid-frame reset sequences.
module tb_uart_tx_ctl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       baud_en = 1'b0;
    logic [7:0] tx_data  [4];
    logic       tx_valid [4];
    logic       tx_ready [4];
    logic       tx_line  [4];
    logic       tx_busy  [4];
    logic       tx_done  [4];

    int n_pass  = 0;
    int n_total = 0;
    int div_cnt = 0;

    typedef struct {
        int          idx;
        logic [7:0]  data;
        logic [11:0] bits;
        int          nbits;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    // Enable on every third clock, updated away from the active edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            div_cnt = (div_cnt == 2) ? 0 : div_cnt + 1;
            baud_en = (div_cnt == 0);
        end
    end

    uart_tx_ctl #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_8n1 (
        .i_clk(clk), .i_rst(rst), .i_baud_x16_en(baud_en),
        .i_tx_data(tx_data[0]), .i_tx_valid(tx_valid[0]), .o_tx_ready(tx_ready[0]),
        .o_tx(tx_line[0]), .o_tx_busy(tx_busy[0]), .o_tx_done(tx_done[0])
    );

    uart_tx_ctl #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut_8e1 (
        .i_clk(clk), .i_rst(rst), .i_baud_x16_en(baud_en),
        .i_tx_data(tx_data[1]), .i_tx_valid(tx_valid[1]), .o_tx_ready(tx_ready[1]),
        .o_tx(tx_line[1]), .o_tx_busy(tx_busy[1]), .o_tx_done(tx_done[1])
    );

    uart_tx_ctl #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut_8o1 (
        .i_clk(clk), .i_rst(rst), .i_baud_x16_en(baud_en),
        .i_tx_data(tx_data[2]), .i_tx_valid(tx_valid[2]), .o_tx_ready(tx_ready[2]),
        .o_tx(tx_line[2]), .o_tx_busy(tx_busy[2]), .o_tx_done(tx_done[2])
    );

    uart_tx_ctl #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_dut_8n2 (
        .i_clk(clk), .i_rst(rst), .i_baud_x16_en(baud_en),
        .i_tx_data(tx_data[3]), .i_tx_valid(tx_valid[3]), .o_tx_ready(tx_ready[3]),
        .o_tx(tx_line[3]), .o_tx_busy(tx_busy[3]), .o_tx_done(tx_done[3])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Return #1 after the next clock edge on which the enable is sampled high.
    task automatic tick();
        do @(posedge clk); while (!baud_en);
        #1;
    endtask

    // Accept a word on an edge that also carries an enable (which must not count),
    // then advance to the enable that begins the start bit.
    task automatic start_frame(input int idx, input logic [7:0] data);
        do begin
            @(posedge clk);
            #3;
        end while (!baud_en);
        tx_data[idx]  = data;
        tx_valid[idx] = 1'b1;
        @(posedge clk);
        #1;
        tx_valid[idx] = 1'b0;
        chk("ready_after_accept", tx_ready[idx], 0);
        chk("idle_on_accept_enable", {tx_busy[idx], tx_line[idx]}, 2'b01);
        tick();
    endtask

    // Called just after the enable that begins the start bit.
    task automatic run_frame(input int idx, input logic [11:0] bits, input int nbits,
                             input logic next);
        chk("busy_at_start", tx_busy[idx], 1);
        chk("ready_at_drain", tx_ready[idx], 1);
        for (int k = 0; k < nbits * 16; k++) begin
            if (k > 0) tick();
            if (k % 16 == 0 || k % 16 == 15)
                chk($sformatf("bit%0d_en%0d", k / 16, k), tx_line[idx], bits[k / 16]);
            if (k == nbits * 16 - 1) chk("done_early", tx_done[idx], 0);
        end
        tick();
        chk("done_pulse", tx_done[idx], 1);
        chk("line_after_stop", tx_line[idx], next ? 0 : 1);
        chk("busy_after_stop", tx_busy[idx], next);
        chk("ready_after_stop", tx_ready[idx], 1);
        @(posedge clk);
        #1;
        chk("done_one_cycle", tx_done[idx], 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            tx_data[i]  = 8'h00;
            tx_valid[i] = 1'b0;
        end
        vecs[0] = '{0, 8'hA5, 12'h34A, 10};
        vecs[1] = '{1, 8'h07, 12'h60E, 11};
        vecs[2] = '{2, 8'h07, 12'h40E, 11};
        vecs[3] = '{3, 8'h55, 12'h6AA, 11};
        vecs[4] = '{1, 8'h00, 12'h400, 11};
        vecs[5] = '{2, 8'hFF, 12'h7FE, 11};

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", tx_line[0], 1);
        chk("rst_ready", tx_ready[0], 1);
        chk("rst_busy", tx_busy[0], 0);
        chk("rst_done", tx_done[0], 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_tx", tx_line[0], 1);
        chk("post_rst_ready", tx_ready[0], 1);
        repeat (20) tick();
        chk("idle_en_tx", tx_line[0], 1);
        chk("idle_en_busy", tx_busy[0], 0);

        for (int v = 0; v < 6; v++) begin
            start_frame(vecs[v].idx, vecs[v].data);
            run_frame(vecs[v].idx, vecs[v].bits, vecs[v].nbits, 1'b0);
        end

        // Back-to-back 0x00 then 0xFF, with valid held (and data changed) while full.
        start_frame(0, 8'h00);
        fork
            run_frame(0, 12'h200, 10, 1'b1);
            begin
                repeat (5) @(posedge clk);
                #3;
                tx_data[0]  = 8'hFF;
                tx_valid[0] = 1'b1;
                @(posedge clk);
                #1;
                chk("b2b_ready_drop", tx_ready[0], 0);
                tx_data[0] = 8'h33;
                repeat (50) @(posedge clk);
                #1;
                chk("b2b_valid_ignored", tx_ready[0], 0);
                tx_valid[0] = 1'b0;
            end
        join
        run_frame(0, 12'h3FE, 10, 1'b0);
        repeat (40) tick();
        chk("b2b_no_third_tx", tx_line[0], 1);
        chk("b2b_no_third_busy", tx_busy[0], 0);

        // Reset mid-frame with a second word buffered.
        start_frame(0, 8'h3C);
        repeat (20) tick();
        @(posedge clk);
        #3;
        tx_data[0]  = 8'h99;
        tx_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        tx_valid[0] = 1'b0;
        chk("mid_buf_ready", tx_ready[0], 0);
        repeat (50) tick();
        chk("mid_data_bit3", tx_line[0], 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_tx", tx_line[0], 1);
        chk("async_rst_busy", tx_busy[0], 0);
        chk("async_rst_ready", tx_ready[0], 1);
        chk("async_rst_done", tx_done[0], 0);
        #10;
        rst = 1'b1;
        repeat (40) tick();
        chk("discard_tx", tx_line[0], 1);
        chk("discard_busy", tx_busy[0], 0);
        chk("discard_ready", tx_ready[0], 1);
        start_frame(0, 8'h81);
        run_frame(0, 12'h302, 10, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
